sprite_palette_encoder: RTL and testbench
=========================================

Name: sprite_palette_encoder

Overview:
- Writer side of the palette-indexed sprite storage format: image RAM holds 8-bit palette indices, palette RAM holds 12-bit RGB.
- Accepts a raster-ordered stream of 12-bit RGB pixels and assigns or reuses palette indices on the fly.
- Drives the write ports of the image and palette BRAMs so a sprite renderer can later read them back.
- Sits between the pixel source (camera or UART loader) and the sprite memories.

Parameters:
- WIDTH, 256, sprite width in pixels.
- HEIGHT, 256, sprite height in pixels.
- PALETTE_DEPTH, 16, maximum distinct colours held in the register palette; legal range 2..256.

Ports:
- pixel_clk_in  in  1  sole clock.
- rst_in  in  1  reset, asynchronous, active-low.
- start_in  in  1  begin encoding a new image; honoured only in IDLE.
- pixel_in  in  12  RGB444 pixel.
- pixel_valid_in  in  1  pixel_in valid.
- pixel_ready_out  out  1  encoder can accept a pixel.
- img_we_out  out  1  image RAM write enable.
- img_addr_out  out  $clog2(WIDTH*HEIGHT)  image RAM address.
- img_data_out  out  8  palette index to write.
- pal_we_out  out  1  palette RAM write enable.
- pal_addr_out  out  8  palette RAM address.
- pal_data_out  out  12  palette colour.
- busy_out  out  1  high in RUN.
- done_out  out  1  one-cycle pulse when the image is complete.
- overflow_out  out  1  sticky; a colour arrived while the palette was full.
- colors_used_out  out  9  number of allocated palette entries.

Behaviour:
- Reset (rst_in low, asynchronous): state IDLE; all outputs 0; every palette entry invalid; pixel counter 0. Reset asserted mid-image abandons the image and produces no further writes.
- States:
  - IDLE -> RUN on start_in. This clears palette valid bits, colors_used_out, overflow_out and the pixel counter.
  - RUN -> IDLE after the handshake of pixel WIDTH*HEIGHT-1.
- pixel_ready_out = 1 only in RUN. A handshake occurs when pixel_valid_in and pixel_ready_out are both high. start_in is ignored in RUN.
- On a handshake in cycle N, pixel_in is compared in parallel against all valid palette registers:
  - Hit: index = lowest matching entry.
  - Miss with colors_used < PALETTE_DEPTH: index = colors_used. Entry is stored and marked valid at the edge ending N; colors_used increments. In cycle N+1: pal_we_out=1, pal_addr_out=index, pal_data_out=pixel_in.
  - Miss with palette full: index = 0; overflow_out set and held until the next start_in.
- Cycle N+1 for every handshake: img_we_out=1, img_addr_out = pixel counter value at N, img_data_out = index. Latency is exactly 1 cycle. Write strobes are 0 in all other cycles.
- Back-to-back handshakes (one per cycle) are sustained with no stall. A colour allocated at N is a hit if it repeats at N+1, because palette registers update at the edge.
- Pixel counter increments per handshake. It never wraps within an image; the handshake with count WIDTH*HEIGHT-1 ends RUN.
- done_out pulses in the same cycle as the final img_we_out. busy_out falls in that cycle.
- A start_in in the done_out cycle is honoured, since the FSM is already IDLE.
- colors_used_out saturates at PALETTE_DEPTH.

Optional Feature:
Macro TRANSPARENT_KEY_EN.
- Defined:
  - Index 0 is reserved as transparent/black.
  - On start_in, entry 0 is preloaded with 12'h000 (valid), colors_used becomes 1, and pal_we_out pulses the cycle after start with addr 0, data 12'h000.
  - Pixel 12'h000 always maps to index 0.
  - Palette-full misses also map to 0.
- Undefined: no preload; 12'h000 is an ordinary colour allocated in arrival order.

Test Plan:
- 4x2 image, PALETTE_DEPTH=4, macro undefined; pixels F00,F00,0F0,F00,00F,0F0,FFF,00F, valid held high -> image writes addr0..7 data 0,0,1,0,2,1,3,2; palette writes (0,F00),(1,0F0),(2,00F),(3,FFF); done_out pulses with write 7; overflow_out=0.
- Same stream with PALETTE_DEPTH=2 -> 00F and FFF map to index 0; overflow_out=1; colors_used_out=2.
- pixel_valid_in toggling 1,0,1,0 -> exactly one write per handshake; addresses contiguous; no write in idle cycles.
- rst_in low during pixel 3 of 8 -> all outputs 0 immediately; no done_out. A new start_in after reset restarts at addr 0 with an empty palette.
- TRANSPARENT_KEY_EN defined; start then pixels 000,ABC,000 -> palette write (0,000) after start, then (1,ABC); image data 0,1,0.

Source files
------------

// File: rtl/sprite_palette_encoder.sv
// Streams raster-ordered RGB444 pixels into palette-indexed sprite storage,
// driving image and palette BRAM write ports. Optional TRANSPARENT_KEY_EN reserves index 0 for 12'h000.
module sprite_palette_encoder #(
    parameter int WIDTH         = 256,
    parameter int HEIGHT        = 256,
    parameter int PALETTE_DEPTH = 16
) (
    input  logic                                pixel_clk_in,
    input  logic                                rst_in,
    input  logic                                start_in,
    input  logic [11:0]                         pixel_in,
    input  logic                                pixel_valid_in,
    output logic                                pixel_ready_out,
    output logic                                img_we_out,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]     img_addr_out,
    output logic [7:0]                          img_data_out,
    output logic                                pal_we_out,
    output logic [7:0]                          pal_addr_out,
    output logic [11:0]                         pal_data_out,
    output logic                                busy_out,
    output logic                                done_out,
    output logic                                overflow_out,
    output logic [8:0]                          colors_used_out
);
    // state  | meaning
    // S_IDLE | waiting for start_in; palette and outputs hold last image's result
    // S_RUN  | accepting pixels, one handshake per cycle

    localparam int NPIX = WIDTH * HEIGHT;
    localparam int AW   = $clog2(NPIX);
    localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
    localparam logic [8:0]    DEPTH9    = 9'(PALETTE_DEPTH);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [11:0]              pal_color [PALETTE_DEPTH];
    logic [PALETTE_DEPTH-1:0] pal_valid;
    logic [8:0]               colors_used;
    logic [AW-1:0]            pix_cnt;
    logic                     overflow;

    logic                     start_go;
    logic                     handshake;
    logic                     last_pixel;
    logic [PALETTE_DEPTH-1:0] match;
    logic                     hit;
    logic [7:0]               hit_idx;
    logic                     key_hit;
    logic                     pal_full;
    logic                     alloc;
    logic                     full_miss;
    logic [7:0]               pix_idx;

    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        start_go        = 1'b0;
        handshake       = 1'b0;
        pixel_ready_out = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_in) begin
                    start_go  = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                pixel_ready_out = 1'b1;
                if (pixel_valid_in) begin
                    handshake = 1'b1;
                    if (pix_cnt == LAST_ADDR) state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign last_pixel = (pix_cnt == LAST_ADDR);
    assign busy_out   = (state == S_RUN);

    // Parallel compare against every valid entry; the lowest match wins.
    always_comb begin
        for (int i = 0; i < PALETTE_DEPTH; i++) begin
            match[i] = pal_valid[i] && (pal_color[i] == pixel_in);
        end
    end

    always_comb begin
        hit     = |match;
        hit_idx = 8'd0;
        for (int i = PALETTE_DEPTH - 1; i >= 0; i--) begin
            if (match[i]) hit_idx = 8'(i);
        end
    end

`ifdef TRANSPARENT_KEY_EN
    assign key_hit = (pixel_in == 12'h000);
`else
    assign key_hit = 1'b0;
`endif

    assign pal_full  = (colors_used >= DEPTH9);
    assign alloc     = handshake && !hit && !key_hit && !pal_full;
    assign full_miss = handshake && !hit && !key_hit && pal_full;

    always_comb begin
        pix_idx = 8'd0;
        if (key_hit)        pix_idx = 8'd0;
        else if (hit)       pix_idx = hit_idx;
        else if (!pal_full) pix_idx = colors_used[7:0];
    end

    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            pal_valid   <= '0;
            colors_used <= 9'd0;
            overflow    <= 1'b0;
            for (int i = 0; i < PALETTE_DEPTH; i++) pal_color[i] <= 12'h000;
        end else if (start_go) begin
            overflow <= 1'b0;
`ifdef TRANSPARENT_KEY_EN
            pal_valid    <= PALETTE_DEPTH'(1);
            pal_color[0] <= 12'h000;
            colors_used  <= 9'd1;
`else
            pal_valid   <= '0;
            colors_used <= 9'd0;
`endif
        end else begin
            if (alloc) begin
                for (int i = 0; i < PALETTE_DEPTH; i++) begin
                    if (colors_used == 9'(i)) begin
                        pal_valid[i] <= 1'b1;
                        pal_color[i] <= pixel_in;
                    end
                end
                colors_used <= colors_used + 9'd1;
            end
            if (full_miss) overflow <= 1'b1;
        end
    end

    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in)          pix_cnt <= '0;
        else if (start_go)    pix_cnt <= '0;
        else if (handshake && !last_pixel) pix_cnt <= pix_cnt + AW'(1);
    end

    // Write ports are registered: every handshake lands exactly one cycle later.
    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            img_we_out   <= 1'b0;
            img_addr_out <= '0;
            img_data_out <= 8'd0;
            pal_we_out   <= 1'b0;
            pal_addr_out <= 8'd0;
            pal_data_out <= 12'h000;
            done_out     <= 1'b0;
        end else begin
            img_we_out <= handshake;
            done_out   <= handshake && last_pixel;
            if (handshake) begin
                img_addr_out <= pix_cnt;
                img_data_out <= pix_idx;
            end
`ifdef TRANSPARENT_KEY_EN
            pal_we_out <= alloc || start_go;
            if (start_go) begin
                pal_addr_out <= 8'd0;
                pal_data_out <= 12'h000;
            end else if (alloc) begin
                pal_addr_out <= colors_used[7:0];
                pal_data_out <= pixel_in;
            end
`else
            pal_we_out <= alloc;
            if (alloc) begin
                pal_addr_out <= colors_used[7:0];
                pal_data_out <= pixel_in;
            end
`endif
        end
    end

    assign overflow_out    = overflow;
    assign colors_used_out = colors_used;

endmodule

// File: tb/tb_sprite_palette_encoder.sv
// Bench for sprite_palette_encoder: two 4x2 instances (palette depth 4 and 2) share one stimulus
// stream; a queue-level palette model predicts every output each cycle, plus literal expectations.
module tb_sprite_palette_encoder;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int N  = W * H;
    localparam int AW = $clog2(N);
`ifdef TRANSPARENT_KEY_EN
    localparam bit TK = 1'b1;
`else
    localparam bit TK = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        valid = 1'b0;
    logic [11:0] pix   = 12'h000;

    logic [1:0]    rdy, iwe, pwe, bsy, dn, ovf;
    logic [AW-1:0] iaddr [2];
    logic [7:0]    idata [2];
    logic [7:0]    paddr [2];
    logic [11:0]   pdata [2];
    logic [8:0]    cused [2];

    always #5 clk = ~clk;

    sprite_palette_encoder #(.WIDTH(W), .HEIGHT(H), .PALETTE_DEPTH(4)) dut4 (
        .pixel_clk_in(clk), .rst_in(rst_n), .start_in(start), .pixel_in(pix),
        .pixel_valid_in(valid), .pixel_ready_out(rdy[0]), .img_we_out(iwe[0]),
        .img_addr_out(iaddr[0]), .img_data_out(idata[0]), .pal_we_out(pwe[0]),
        .pal_addr_out(paddr[0]), .pal_data_out(pdata[0]), .busy_out(bsy[0]),
        .done_out(dn[0]), .overflow_out(ovf[0]), .colors_used_out(cused[0]));

    sprite_palette_encoder #(.WIDTH(W), .HEIGHT(H), .PALETTE_DEPTH(2)) dut2 (
        .pixel_clk_in(clk), .rst_in(rst_n), .start_in(start), .pixel_in(pix),
        .pixel_valid_in(valid), .pixel_ready_out(rdy[1]), .img_we_out(iwe[1]),
        .img_addr_out(iaddr[1]), .img_data_out(idata[1]), .pal_we_out(pwe[1]),
        .pal_addr_out(paddr[1]), .pal_data_out(pdata[1]), .busy_out(bsy[1]),
        .done_out(dn[1]), .overflow_out(ovf[1]), .colors_used_out(cused[1]));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, d, act, exp, $time);
        end
    endtask

    // Model: palette as a plain list of colours, searched linearly.
    int          m_depth [2] = '{4, 2};
    bit          m_run   [2] = '{0, 0};
    int          m_cnt   [2] = '{0, 0};
    int          m_size  [2] = '{0, 0};
    bit          m_ov    [2] = '{0, 0};
    logic [11:0] m_pal   [2][256];
    bit          e_iwe   [2] = '{0, 0};
    int          e_iaddr [2] = '{0, 0};
    int          e_idata [2] = '{0, 0};
    bit          e_pwe   [2] = '{0, 0};
    int          e_paddr [2] = '{0, 0};
    int          e_pdata [2] = '{0, 0};
    bit          e_done  [2] = '{0, 0};

    initial forever begin
        @(posedge clk or negedge rst_n);
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_run[d] = 0; m_cnt[d] = 0; m_size[d] = 0; m_ov[d] = 0;
                e_iwe[d] = 0; e_pwe[d] = 0; e_done[d] = 0;
            end else begin
                e_iwe[d] = 0; e_pwe[d] = 0; e_done[d] = 0;
                if (m_run[d] && valid) begin
                    int idx;
                    idx = -1;
                    for (int j = 0; j < m_size[d]; j++)
                        if (idx < 0 && m_pal[d][j] == pix) idx = j;
                    if (TK && pix == 12'h000) idx = 0;
                    if (idx < 0) begin
                        if (m_size[d] < m_depth[d]) begin
                            idx = m_size[d];
                            m_pal[d][idx] = pix;
                            m_size[d]++;
                            e_pwe[d] = 1; e_paddr[d] = idx; e_pdata[d] = int'(pix);
                        end else begin
                            idx = 0;
                            m_ov[d] = 1;
                        end
                    end
                    e_iwe[d] = 1; e_iaddr[d] = m_cnt[d]; e_idata[d] = idx;
                    if (m_cnt[d] == N - 1) begin
                        m_run[d] = 0; e_done[d] = 1;
                    end else m_cnt[d]++;
                end else if (!m_run[d] && start) begin
                    m_run[d] = 1; m_cnt[d] = 0; m_size[d] = 0; m_ov[d] = 0;
                    if (TK) begin
                        m_pal[d][0] = 12'h000; m_size[d] = 1;
                        e_pwe[d] = 1; e_paddr[d] = 0; e_pdata[d] = 0;
                    end
                end
            end
        end
    end

    int img_a [2][$];
    int img_d [2][$];
    int pal_a [2][$];
    int pal_d [2][$];
    int done_cnt  [2] = '{0, 0};
    int done_addr [2] = '{-1, -1};

    initial forever begin
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("img_we", d, iwe[d], e_iwe[d]);
            if (e_iwe[d]) begin
                chk("img_addr", d, iaddr[d], e_iaddr[d]);
                chk("img_data", d, idata[d], e_idata[d]);
            end
            chk("pal_we", d, pwe[d], e_pwe[d]);
            if (e_pwe[d]) begin
                chk("pal_addr", d, paddr[d], e_paddr[d]);
                chk("pal_data", d, pdata[d], e_pdata[d]);
            end
            chk("done", d, dn[d], e_done[d]);
            chk("busy", d, bsy[d], m_run[d]);
            chk("ready", d, rdy[d], m_run[d]);
            chk("overflow", d, ovf[d], m_ov[d]);
            chk("colors_used", d, cused[d], m_size[d]);
            if (iwe[d]) begin img_a[d].push_back(int'(iaddr[d])); img_d[d].push_back(int'(idata[d])); end
            if (pwe[d]) begin pal_a[d].push_back(int'(paddr[d])); pal_d[d].push_back(int'(pdata[d])); end
            if (dn[d]) begin done_cnt[d]++; done_addr[d] = int'(iaddr[d]); end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic send(input logic [11:0] p);
        valid = 1'b1; pix = p; tick(); valid = 1'b0;
    endtask

    task automatic clear_logs();
        for (int d = 0; d < 2; d++) begin
            img_a[d].delete(); img_d[d].delete(); pal_a[d].delete(); pal_d[d].delete();
            done_cnt[d] = 0; done_addr[d] = -1;
        end
    endtask

    logic [11:0] img1 [8] = '{12'hF00, 12'hF00, 12'h0F0, 12'hF00, 12'h00F, 12'h0F0, 12'hFFF, 12'h00F};
    logic [11:0] img2 [8] = '{12'h123, 12'h456, 12'h123, 12'h789, 12'hABC, 12'h456, 12'hDEF, 12'h123};
    int exp_d4 [8] = '{0, 0, 1, 0, 2, 1, 3, 2};
    int exp_d2 [8] = '{0, 0, 1, 0, 0, 1, 0, 0};
    int exp_pa [4] = '{0, 1, 2, 3};
    int exp_pd [4] = '{'hF00, 'h0F0, 'h00F, 'hFFF};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int pre_rst;
        #2 rst_n = 1'b0;
        repeat (2) tick();
        for (int d = 0; d < 2; d++) begin
            chk("reset_busy", d, bsy[d], 1'b0);
            chk("reset_colors", d, cused[d], 9'd0);
        end
        rst_n = 1'b1;
        tick();

        // Image 1, valid held high
        clear_logs();
        do_start();
        for (int i = 0; i < 8; i++) send(img1[i]);
        chk("t1_done_now", 0, dn[0], 1'b1);
        chk("t1_busy_low", 0, bsy[0], 1'b0);
        if (!TK) begin
            chk("t1_overflow", 0, ovf[0], 1'b0);
            chk("t1_colors", 0, cused[0], 9'd4);
            chk("t1_overflow", 1, ovf[1], 1'b1);
            chk("t1_colors", 1, cused[1], 9'd2);
        end
        start = 1'b1; tick(); start = 1'b0;   // start in the done cycle
        chk("t1_restart_busy", 0, bsy[0], 1'b1);
        chk("t1_done_addr", 0, done_addr[0], 7);
        chk("t1_img_count", 0, img_a[0].size(), 8);
        if (!TK && img_a[0].size() == 8 && img_a[1].size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("t1_addr", 0, img_a[0][i], i);
                chk("t1_data4", 0, img_d[0][i], exp_d4[i]);
                chk("t1_data2", 1, img_d[1][i], exp_d2[i]);
            end
        end
        if (!TK) begin
            chk("t1_pal_count", 0, pal_a[0].size(), 4);
            if (pal_a[0].size() == 4)
                for (int i = 0; i < 4; i++) begin
                    chk("t1_pal_addr", 0, pal_a[0][i], exp_pa[i]);
                    chk("t1_pal_data", 0, pal_d[0][i], exp_pd[i]);
                end
        end

        // Image 2, valid toggling, start ignored while running
        clear_logs();
        for (int i = 0; i < 8; i++) begin
            send(img2[i]);
            if (i == 3) start = 1'b1;
            tick();
            start = 1'b0;
        end
        chk("t2_img_count", 0, img_a[0].size(), 8);
        chk("t2_done_count", 0, done_cnt[0], 1);
        if (img_a[0].size() == 8)
            for (int i = 0; i < 8; i++) chk("t2_addr", 0, img_a[0][i], i);

        // Reset during pixel 3
        clear_logs();
        do_start();
        send(img1[0]);
        send(img1[1]);
        valid = 1'b1; pix = img1[2];
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_img_we", d, iwe[d], 1'b0);
            chk("rst_pal_we", d, pwe[d], 1'b0);
            chk("rst_busy", d, bsy[d], 1'b0);
            chk("rst_ready", d, rdy[d], 1'b0);
            chk("rst_colors", d, cused[d], 9'd0);
        end
        pre_rst = img_a[0].size();
        tick(); tick();
        valid = 1'b0;
        rst_n = 1'b1;
        repeat (3) tick();
        chk("rst_no_writes", 0, img_a[0].size(), pre_rst);
        chk("rst_no_done", 0, done_cnt[0], 0);

        clear_logs();
        do_start();
        for (int i = 0; i < 8; i++) send(img1[i]);
        tick();
        chk("rst2_img_count", 0, img_a[0].size(), 8);
        chk("rst2_done", 0, done_cnt[0], 1);
        if (img_a[0].size() > 0) chk("rst2_first_addr", 0, img_a[0][0], 0);
        if (pal_a[0].size() > 0) begin
            chk("rst2_first_pal_addr", 0, pal_a[0][0], 0);
            chk("rst2_first_pal_data", 0, pal_d[0][0], TK ? 0 : 'hF00);
        end else chk("rst2_pal_count", 0, pal_a[0].size(), 1);

`ifdef TRANSPARENT_KEY_EN
        clear_logs();
        do_start();
        send(12'h000); send(12'hABC); send(12'h000);
        for (int i = 0; i < 5; i++) send(12'h000);
        tick();
        chk("tk_pal_count", 0, pal_a[0].size(), 2);
        if (pal_a[0].size() == 2) begin
            chk("tk_pal0_addr", 0, pal_a[0][0], 0);
            chk("tk_pal0_data", 0, pal_d[0][0], 0);
            chk("tk_pal1_addr", 0, pal_a[0][1], 1);
            chk("tk_pal1_data", 0, pal_d[0][1], 'hABC);
        end
        if (img_d[0].size() >= 3) begin
            chk("tk_data0", 0, img_d[0][0], 0);
            chk("tk_data1", 0, img_d[0][1], 1);
            chk("tk_data2", 0, img_d[0][2], 0);
        end else chk("tk_img_count", 0, img_d[0].size(), 8);
`endif

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
